// File: rtl/module_cla_multiword_ctrl.sv
// Wide add/subtract sequencer: one CLA slice reused across NUM_WORDS words, carry chained
// through a register, operands and result exchanged on valid/ready handshakes.

module module_carry_look_ahead_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  localparam int unsigned GROUPS = WIDTH / 4;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // 4-bit lookahead groups; each group's carry-out depends only on its carry-in
  always_comb begin
    c    = '0;
    c[0] = carry_in;
    for (int k = 0; k < int'(GROUPS); k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
  end

  assign sum       = p ^ c[WIDTH-1:0];
  assign carry_out = c[WIDTH];
endmodule

module module_cla_multiword_ctrl #(
  parameter int unsigned CLA_WIDTH = 16,
  parameter int unsigned NUM_WORDS = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic [CLA_WIDTH*NUM_WORDS-1:0] a_i,
  input  logic [CLA_WIDTH*NUM_WORDS-1:0] b_i,
  input  logic                           sub_i,
  input  logic                           carry_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [CLA_WIDTH*NUM_WORDS-1:0] sum_o,
  output logic                           carry_o,
  output logic                           busy_o
);
  localparam int unsigned W     = CLA_WIDTH * NUM_WORDS;
  localparam int unsigned CNT_W = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state;
  state_t               state_d;
  logic [W-1:0]         a_q;
  logic [W-1:0]         b_q;
  logic                 carry_q;
  logic [CNT_W-1:0]     word_cnt;
  logic [W-1:0]         sum_q;
  logic                 carry_out_q;
  logic                 ready_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 ready_d;
  logic                 valid_d;
  logic                 busy_d;
  logic                 last_word;
  logic [CLA_WIDTH-1:0] cla_a;
  logic [CLA_WIDTH-1:0] cla_b;
  logic [CLA_WIDTH-1:0] cla_sum;
  logic                 cla_cout;

  assign last_word = (word_cnt == CNT_W'(NUM_WORDS - 1));
  assign cla_a     = a_q[word_cnt*CLA_WIDTH +: CLA_WIDTH];
  assign cla_b     = b_q[word_cnt*CLA_WIDTH +: CLA_WIDTH];

  module_carry_look_ahead_adder #(.WIDTH(CLA_WIDTH)) u_cla (
    .a         (cla_a),
    .b         (cla_b),
    .carry_in  (carry_q),
    .sum       (cla_sum),
    .carry_out (cla_cout)
  );

  // Next state and registered handshake/status flags
  always_comb begin
    state_d = state;
    ready_d = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    case (state)
      IDLE:    if (valid_i)   state_d = BUSY;
      BUSY:    if (last_word) state_d = DONE;
      DONE:    if (ready_i)   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      word_cnt    <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state   <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      case (state)
        IDLE: begin
          if (valid_i) begin
            // Subtract as A + ~B + 1
            a_q      <= a_i;
            b_q      <= sub_i ? ~b_i : b_i;
            carry_q  <= sub_i ? 1'b1 : carry_i;
            word_cnt <= '0;
            sum_q    <= '0;
          end
        end
        BUSY: begin
          sum_q[word_cnt*CLA_WIDTH +: CLA_WIDTH] <= cla_sum;
          carry_q  <= cla_cout;
          word_cnt <= last_word ? '0 : word_cnt + CNT_W'(1);
          if (last_word) carry_out_q <= cla_cout;
        end
        DONE: begin
          if (ready_i) word_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign sum_o   = sum_q;
  assign carry_o = carry_out_q;
endmodule

// File: tb/tb_module_cla_multiword_ctrl.sv
// Self-checking bench for module_cla_multiword_ctrl: directed table, backpressure, reset abort,
// and randomized transactions against a flat 65-bit arithmetic reference.

module tb_module_cla_multiword_ctrl;
  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         sub_i;
  logic         carry_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] sum_o;
  logic         carry_o;
  logic         busy_o;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_carry;
  } vec_t;

  vec_t tbl[7];

  module_cla_multiword_ctrl #(.CLA_WIDTH(16), .NUM_WORDS(4)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .a_i     (a_i),
    .b_i     (b_i),
    .sub_i   (sub_i),
    .carry_i (carry_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .sum_o   (sum_o),
    .carry_o (carry_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sub, input logic cin);
    if (sub) return {(a >= b), a - b};
    return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Present operands on a falling edge; accepted at the following rising edge
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic c,
                      input logic scramble);
    @(negedge clk);
    a_i = a; b_i = b; sub_i = s; carry_i = c; valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (scramble) begin
      a_i = {$urandom(), $urandom()}; b_i = {$urandom(), $urandom()};
      sub_i = 1'($urandom_range(0, 1)); carry_i = 1'($urandom_range(0, 1));
      valid_i = 1'($urandom_range(0, 1));
    end else begin
      valid_i = 1'b0;
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!valid_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result(input string name);
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check(name, 128'({ready_o, valid_o, busy_o}), 128'(3'b100));
    ready_i = 1'b0;
  endtask

  initial begin
    int lat;
    logic [W:0] expv;
    logic seen_valid;

    tbl[0] = '{64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0001_0000_0000_0000, 1'b0};
    tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1};
    tbl[2] = '{64'h5, 64'h7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    tbl[3] = '{64'h7, 64'h5, 1'b1, 1'b0, 64'h2, 1'b1};
    tbl[4] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1,
               64'h2222_2222_2222_2212, 1'b0};
    tbl[5] = '{64'h0, 64'h0, 1'b1, 1'b1, 64'h0, 1'b1};
    tbl[6] = '{64'h0, 64'h1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    a_i = '0; b_i = '0; sub_i = 1'b0; carry_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", 128'({ready_o, valid_o, busy_o, carry_o, sum_o}), 128'({3'b100, 1'b0, 64'h0}));
    rst_i = 1'b0;

    for (int i = 0; i < 7; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin, 1'b0);
      check($sformatf("accept[%0d]", i), 128'({busy_o, ready_o, valid_o}), 128'(3'b100));
      wait_done(lat);
      check($sformatf("latency[%0d]", i), 128'(lat), 128'(4));
      check($sformatf("result[%0d]", i), 128'({carry_o, sum_o}),
            128'({tbl[i].exp_carry, tbl[i].exp_sum}));
      release_result($sformatf("release[%0d]", i));
    end

    // Backpressure: result held for 10 cycles while new operands are offered
    send(tbl[4].a, tbl[4].b, tbl[4].sub, tbl[4].cin, 1'b0);
    wait_done(lat);
    a_i = 64'hDEAD_BEEF_0000_0001; b_i = 64'h1; sub_i = 1'b0; valid_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp_hold[%0d]", c), 128'({valid_o, ready_o, busy_o, carry_o, sum_o}),
            128'({3'b101, tbl[4].exp_carry, tbl[4].exp_sum}));
      @(negedge clk);
    end
    release_result("bp_release");
    check("bp_after", 128'({carry_o, sum_o}), 128'({tbl[4].exp_carry, tbl[4].exp_sum}));

    // Reset while two words are still outstanding
    send(64'h7, 64'h5, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("rst_busy", 128'({ready_o, valid_o, busy_o, carry_o, sum_o}), 128'({3'b100, 1'b0, 64'h0}));
    seen_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen_valid |= valid_o;
    end
    check("rst_no_valid", 128'(seen_valid), 128'(0));

    for (int t = 0; t < 200; t++) begin
      logic [W-1:0] ra, rb;
      logic rs, rc, rhi;
      int stall;
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) ra = '1;
      if ($urandom_range(0, 7) == 0) rb = (rb == 0) ? '0 : '1;
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      rhi = 1'($urandom_range(0, 1));
      stall = $urandom_range(0, 3);
      ready_i = rhi;
      send(ra, rb, rs, rc, 1'b1);
      wait_done(lat);
      expv = ref_model(ra, rb, rs, rc);
      check($sformatf("rnd_latency[%0d]", t), 128'(lat), 128'(4));
      if (!rhi) repeat (stall) @(negedge clk);
      check($sformatf("rnd_result[%0d] a=%h b=%h sub=%0d cin=%0d", t, ra, rb, rs, rc),
            128'({valid_o, carry_o, sum_o}), 128'({1'b1, expv}));
      release_result($sformatf("rnd_release[%0d]", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
